// File: rtl/rv32i_insn_encoder.sv
// RV32I instruction encoder: validates class/field descriptors and streams the legal
// encoded words to sequential IMEM addresses through a one-entry output register.
module rv32i_insn_encoder #(
   parameter int P_ADDR_W = 8,
   parameter int P_DEPTH  = 256
) (
   input  logic                i_clk,
   input  logic                i_reset,
   input  logic                i_clr,
   input  logic                i_req_vld,
   output logic                o_req_rdy,
   input  logic [3:0]          i_cls,
   input  logic [2:0]          i_funct3,
   input  logic                i_alt,
   input  logic [4:0]          i_rd,
   input  logic [4:0]          i_rs1,
   input  logic [4:0]          i_rs2,
   input  logic [31:0]         i_imm,
   output logic                o_wr_vld,
   input  logic                i_wr_rdy,
   output logic [P_ADDR_W-1:0] o_wr_addr,
   output logic [31:0]         o_wr_data,
   output logic [P_ADDR_W:0]   o_cnt,
   output logic                o_full,
   output logic                o_err
);

   typedef enum logic [1:0] {IDLE, PEND, FULL} state_t;

   state_t              state_q, state_d;
   logic [P_ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]         data_q, data_d;
   logic [P_ADDR_W:0]   cnt_q, cnt_d;
   logic                err_q, err_d;
   logic                pend_d;

   logic signed [31:0]  simm;
   logic [31:0]         enc;
   logic                legal;
   logic                in12, in13, in21, is_shift, alt_ok;
   logic [6:0]          f7;
   logic                acc, hs;

   assign simm     = i_imm;
   assign in12     = (simm >= -2048) && (simm <= 2047);
   assign in13     = (simm >= -4096) && (simm <= 4094);
   assign in21     = (simm >= -1048576) && (simm <= 1048574);
   assign is_shift = (i_funct3 == 3'b001) || (i_funct3 == 3'b101);
   assign alt_ok   = ((i_cls == 4'd0) && ((i_funct3 == 3'b000) || (i_funct3 == 3'b101))) ||
                     ((i_cls == 4'd1) && (i_funct3 == 3'b101));
   assign f7       = i_alt ? 7'b0100000 : 7'b0000000;

   always_comb begin
      enc   = 32'd0;
      legal = 1'b1;
      case (i_cls)
         4'd0: enc = {f7, i_rs2, i_rs1, i_funct3, i_rd, 7'b0110011};
         4'd1: begin
            if (is_shift) begin
               enc   = {f7, i_imm[4:0], i_rs1, i_funct3, i_rd, 7'b0010011};
               legal = (i_imm[31:5] == 27'd0);
            end else begin
               enc   = {i_imm[11:0], i_rs1, i_funct3, i_rd, 7'b0010011};
               legal = in12;
            end
         end
         4'd2: begin
            enc   = {i_imm[11:0], i_rs1, i_funct3, i_rd, 7'b0000011};
            legal = in12 && (i_funct3 != 3'b011) && (i_funct3 != 3'b110) && (i_funct3 != 3'b111);
         end
         4'd3: begin
            enc   = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], 7'b0100011};
            legal = in12 && (i_funct3 < 3'b011);
         end
         4'd4: begin
            enc   = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], 7'b1100011};
            legal = in13 && !i_imm[0] && (i_funct3 != 3'b010) && (i_funct3 != 3'b011);
         end
         4'd5: begin
            enc   = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, 7'b1101111};
            legal = in21 && !i_imm[0];
         end
         4'd6: begin
            enc   = {i_imm[11:0], i_rs1, i_funct3, i_rd, 7'b1100111};
            legal = in12 && (i_funct3 == 3'b000);
         end
         4'd7: begin
            enc   = {i_imm[31:12], i_rd, 7'b0110111};
            legal = (i_imm[11:0] == 12'd0);
         end
         4'd8: begin
            enc   = {i_imm[31:12], i_rd, 7'b0010111};
            legal = (i_imm[11:0] == 12'd0);
         end
         default: legal = 1'b0;
      endcase
      if (i_alt && !alt_ok) legal = 1'b0;
   end

   assign o_wr_vld  = (state_q == PEND);
   assign o_full    = (cnt_q == (P_ADDR_W+1)'(P_DEPTH));
   assign o_req_rdy = ~i_reset & ~i_clr & ~o_full & (~o_wr_vld | i_wr_rdy);
   assign acc       = i_req_vld & o_req_rdy;
   assign hs        = o_wr_vld & i_wr_rdy;

   always_comb begin
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      pend_d  = o_wr_vld & ~hs;
      state_d = state_q;
      if (i_clr) begin
         cnt_d   = '0;
         err_d   = 1'b0;
         state_d = IDLE;
      end else begin
         if (acc && legal) begin
            addr_d = cnt_q[P_ADDR_W-1:0];
            data_d = enc;
            cnt_d  = cnt_q + (P_ADDR_W+1)'(1);
            pend_d = 1'b1;
         end
         if (acc && !legal) err_d = 1'b1;
         // FULL is only reached once the last word has drained
         if (pend_d)                                  state_d = PEND;
         else if (cnt_d == (P_ADDR_W+1)'(P_DEPTH))    state_d = FULL;
         else                                         state_d = IDLE;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign o_wr_addr = addr_q;
   assign o_wr_data = data_q;
   assign o_cnt     = cnt_q;
   assign o_err     = err_q;

endmodule
